// File: rtl/pll_lock_sequencer.sv
// PLL power-up/recovery sequencer: pulses PLL reset, qualifies LOCKED through a synchroniser
// and glitch filter, retries on lock timeout and reports ready/fault. Runs on the reference clock.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_FILTER  = 64,
  parameter int unsigned LOCK_TIMEOUT = 100000,
  parameter int unsigned MAX_RETRIES  = 3,
  localparam int unsigned RcW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           pll_locked,
  input  logic           restart,
  output logic           pll_rst,
  output logic           pll_pwrdwn,
  output logic           ready,
  output logic           fault,
  output logic [RcW-1:0] retry_count,
  output logic [7:0]     lock_loss_cnt
);

  localparam int unsigned RstW = $clog2(RST_CYCLES + 1);
  localparam int unsigned FltW = $clog2(LOCK_FILTER + 1);
  localparam int unsigned TmoW = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [RstW-1:0] RstLast = RstW'(RST_CYCLES - 1);
  localparam logic [FltW-1:0] FltLast = FltW'(LOCK_FILTER - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(LOCK_TIMEOUT - 1);
  localparam logic [RcW-1:0]  RcMax   = RcW'(MAX_RETRIES);

  localparam logic [1:0] StRstPll   = 2'd0;
  localparam logic [1:0] StWaitLock = 2'd1;
  localparam logic [1:0] StRun      = 2'd2;
  localparam logic [1:0] StFault    = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [RstW-1:0] rst_cnt_q, rst_cnt_d;
  logic [FltW-1:0] flt_q, flt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [RcW-1:0]  retry_q, retry_d;
  logic [7:0]      loss_q, loss_d;
  logic            lk_meta_q, lk_s_q;

  // LOCKED is asynchronous to clk; only lk_s_q is used by the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lk_meta_q <= 1'b0;
      lk_s_q    <= 1'b0;
    end else begin
      lk_meta_q <= pll_locked;
      lk_s_q    <= lk_meta_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    flt_d     = flt_q;
    tmo_d     = tmo_q;
    retry_d   = retry_q;
    loss_d    = loss_q;
    if (restart) begin
      state_d   = StRstPll;
      rst_cnt_d = '0;
      flt_d     = '0;
      tmo_d     = '0;
      retry_d   = '0;
    end else begin
      unique case (state_q)
        StRstPll: begin
          flt_d = '0;
          tmo_d = '0;
          if (rst_cnt_q == RstLast) begin
            state_d   = StWaitLock;
            rst_cnt_d = '0;
          end else begin
            rst_cnt_d = rst_cnt_q + 1'b1;
          end
        end
        StWaitLock: begin
          flt_d = lk_s_q ? flt_q + 1'b1 : '0;
          tmo_d = tmo_q + 1'b1;
          // A lock completing on the timeout cycle takes precedence.
          if (lk_s_q && (flt_q == FltLast)) begin
            state_d = StRun;
            retry_d = '0;
          end else if (tmo_q == TmoLast) begin
            if (retry_q == RcMax) begin
              state_d = StFault;
            end else begin
              state_d   = StRstPll;
              rst_cnt_d = '0;
              retry_d   = retry_q + 1'b1;
            end
          end
        end
        StRun: begin
          if (!lk_s_q) begin
            state_d   = StRstPll;
            rst_cnt_d = '0;
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          end
        end
        StFault: begin
        end
        default: state_d = StRstPll;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StRstPll;
      rst_cnt_q <= '0;
      flt_q     <= '0;
      tmo_q     <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      flt_q     <= flt_d;
      tmo_q     <= tmo_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
    end
  end

  assign pll_rst       = (state_q == StRstPll) || (state_q == StFault);
  assign pll_pwrdwn    = (state_q == StFault);
  assign fault         = (state_q == StFault);
  assign ready         = (state_q == StRun);
  assign retry_count   = retry_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: a per-edge behavioural model feeds a scoreboard
// queue that a separate monitor drains on the falling edge, plus directed timing checks.
module tb_pll_lock_sequencer;

  localparam int unsigned RstCycles   = 4;
  localparam int unsigned LockFilter  = 8;
  localparam int unsigned LockTimeout = 50;
  localparam int unsigned MaxRetries  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       pll_pwrdwn;
  logic       ready;
  logic       fault;
  logic [1:0] retry_count;
  logic [7:0] lock_loss_cnt;

  int checks = 0;
  int errors = 0;

  pll_lock_sequencer #(
    .RST_CYCLES  (RstCycles),
    .LOCK_FILTER (LockFilter),
    .LOCK_TIMEOUT(LockTimeout),
    .MAX_RETRIES (MaxRetries)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pll_locked   (pll_locked),
    .restart      (restart),
    .pll_rst      (pll_rst),
    .pll_pwrdwn   (pll_pwrdwn),
    .ready        (ready),
    .fault        (fault),
    .retry_count  (retry_count),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       pwr;
    logic       rdy;
    logic       flt;
    logic [1:0] rc;
    logic [7:0] ll;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: phase plus time spent in it, measured in clock edges.
  localparam int PhPulse = 0;
  localparam int PhWait  = 1;
  localparam int PhRun   = 2;
  localparam int PhFault = 3;

  int   ph;
  int   elapsed;
  int   hi_run;
  int   m_retries;
  int   m_losses;
  logic s1;
  logic s2;

  task automatic model_reset();
    ph        = PhPulse;
    elapsed   = 0;
    hi_run    = 0;
    m_retries = 0;
    m_losses  = 0;
    s1        = 1'b0;
    s2        = 1'b0;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.rst = (ph == PhPulse) || (ph == PhFault);
    e.pwr = (ph == PhFault);
    e.rdy = (ph == PhRun);
    e.flt = (ph == PhFault);
    e.rc  = 2'(m_retries);
    e.ll  = 8'(m_losses);
    return e;
  endfunction

  task automatic model_step(input logic rst_now, input logic lk, input logic rs);
    logic lks;
    if (rst_now) begin
      model_reset();
    end else begin
      lks = s2;
      s2  = s1;
      s1  = lk;
      if (rs) begin
        ph        = PhPulse;
        elapsed   = 0;
        hi_run    = 0;
        m_retries = 0;
      end else begin
        case (ph)
          PhPulse: begin
            elapsed++;
            if (elapsed >= RstCycles) begin
              ph      = PhWait;
              elapsed = 0;
              hi_run  = 0;
            end
          end
          PhWait: begin
            elapsed++;
            hi_run = lks ? hi_run + 1 : 0;
            if (hi_run >= LockFilter) begin
              ph        = PhRun;
              m_retries = 0;
            end else if (elapsed >= LockTimeout) begin
              if (m_retries == MaxRetries) begin
                ph = PhFault;
              end else begin
                m_retries++;
                ph      = PhPulse;
                elapsed = 0;
              end
            end
          end
          PhRun: begin
            if (!lks) begin
              if (m_losses < 255) m_losses++;
              ph      = PhPulse;
              elapsed = 0;
            end
          end
          default: begin
          end
        endcase
      end
    end
    exp_q.push_back(model_out());
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic chk_range(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, got, lo, hi);
    end
  endtask

  // One clock: drive inputs, let the DUT sample them, advance the model, settle past the edge.
  task automatic cycle(input logic lk, input logic rs);
    pll_locked = lk;
    restart    = rs;
    @(posedge clk);
    model_step(reset, lk, rs);
    #1;
  endtask

  // Monitor: every edge presents a new output word; compare it on the falling edge.
  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = '{pll_rst, pll_pwrdwn, ready, fault, retry_count, lock_loss_cnt};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL scoreboard @%0t: got rst=%b pwr=%b rdy=%b flt=%b rc=%0d ll=%0d, want rst=%b pwr=%b rdy=%b flt=%b rc=%0d ll=%0d",
                   $time, got.rst, got.pwr, got.rdy, got.flt, got.rc, got.ll,
                   e.rst, e.pwr, e.rdy, e.flt, e.rc, e.ll);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int rise;
    int fall;
    int highs;
    int rises;
    logic prev;
    int burst;

    reset      = 1'b1;
    pll_locked = 1'b0;
    restart    = 1'b0;
    model_reset();
    #1;
    chk("reset_pll_rst", int'(pll_rst), 1);
    chk("reset_pwrdwn", int'(pll_pwrdwn), 0);
    chk("reset_ready", int'(ready), 0);
    chk("reset_fault", int'(fault), 0);
    chk("reset_retry", int'(retry_count), 0);
    chk("reset_losses", int'(lock_loss_cnt), 0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    reset = 1'b0;

    // Power-up: LOCKED rises at cycle 6, ready after sync + filter.
    rise  = -1;
    highs = 0;
    for (int c = 0; c < 30; c++) begin
      cycle(c >= 6, 1'b0);
      if (pll_rst) highs++;
      if (ready && rise < 0) rise = c + 1;
    end
    chk_range("t1_ready_rise_cycle", rise, 15, 17);
    chk("t1_rst_cycles_after_edge0", highs, RstCycles - 1);
    chk("t1_retry", int'(retry_count), 0);

    // One-cycle lock drop in RUN.
    fall  = -1;
    highs = 0;
    for (int c = 0; c < 30; c++) begin
      cycle(c != 0, 1'b0);
      if (pll_rst) highs++;
      if (!ready && fall < 0) fall = c;
    end
    chk_range("t4_ready_fall_cycle", fall, 0, 3);
    chk("t4_rst_pulse_len", highs, RstCycles);
    chk("t4_losses", int'(lock_loss_cnt), 1);
    chk("t4_relock_ready", int'(ready), 1);

    // Glitch during WAIT_LOCK restarts the filter.
    cycle(1'b0, 1'b1);
    rise = -1;
    for (int c = 0; c < 40; c++) begin
      cycle((c >= 8 && c <= 12) || c >= 14, 1'b0);
      if (ready && rise < 0) rise = c;
    end
    chk_range("t2_ready_after_glitch", rise, 22, 24);

    // LOCKED never comes: retries then FAULT, held.
    prev  = pll_rst;
    rises = 0;
    cycle(1'b0, 1'b1);
    if (pll_rst && !prev) rises++;
    prev = pll_rst;
    for (int c = 0; c < 3 * (RstCycles + LockTimeout) + 200; c++) begin
      cycle(1'b0, 1'b0);
      if (pll_rst && !prev) rises++;
      prev = pll_rst;
    end
    chk("t3_rst_rises", rises, MaxRetries + 2);
    chk("t3_fault", int'(fault), 1);
    chk("t3_pwrdwn", int'(pll_pwrdwn), 1);
    chk("t3_ready", int'(ready), 0);
    chk("t3_retry", int'(retry_count), MaxRetries);

    // Restart out of FAULT.
    cycle(1'b1, 1'b1);
    chk("t5_fault_cleared", int'(fault), 0);
    chk("t5_pll_rst", int'(pll_rst), 1);
    chk("t5_retry", int'(retry_count), 0);
    for (int c = 0; c < 30; c++) cycle(1'b1, 1'b0);
    chk("t5_ready", int'(ready), 1);

    // Randomised LOCKED with glitches, long outages and occasional restarts.
    burst = 0;
    for (int c = 0; c < 3000; c++) begin
      if (burst == 0 && $urandom_range(0, 149) == 0) burst = $urandom_range(1, 80);
      if (burst > 0) begin
        burst--;
        cycle(1'b0, $urandom_range(0, 299) == 0);
      end else begin
        cycle($urandom_range(0, 99) < 97, $urandom_range(0, 299) == 0);
      end
    end

    // Asynchronous reset mid-WAIT_LOCK.
    cycle(1'b0, 1'b1);
    for (int c = 0; c < RstCycles + 6; c++) cycle(1'b0, 1'b0);
    chk("t6_in_wait", int'(pll_rst), 0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_async_pll_rst", int'(pll_rst), 1);
    chk("t6_async_ready", int'(ready), 0);
    chk("t6_async_losses", int'(lock_loss_cnt), 0);
    chk("t6_async_retry", int'(retry_count), 0);
    model_reset();
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    reset = 1'b0;

    // 300 lock losses: counter must saturate.
    for (int n = 0; n < 300; n++) begin
      for (int c = 0; c < 20; c++) cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
    end
    for (int c = 0; c < 5; c++) cycle(1'b1, 1'b0);
    chk("sat_losses", int'(lock_loss_cnt), 255);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
